fetch_unit: RTL and testbench

Instruction fetch stage between the program counter and decode. It owns the fetch PC, drives the byte address of the asynchronous instruction ROM, and captures each returned 32-bit little-endian word into a small FIFO. Decode drains the FIFO over a valid/ready handshake. A redirect from execute (branch or jump) flushes the queue and restarts fetch at the new PC.

---
 rtl/fetch_unit.sv | 107 ++++++++++
 tb/tb_fetch_unit.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage feeding decode through a small {pc, instr} queue.
// Optional macro FETCH_MISALIGN_CHK_EN: a misaligned redirect raises a sticky
// misalign_err and halts fetch until reset. Without it the low PC bits are masked.
module fetch_unit #(
    parameter int unsigned              ADDRESS_WIDTH = 32,
    parameter int unsigned              DATA_WIDTH    = 32,
    parameter int unsigned              DEPTH         = 4,
    parameter logic [ADDRESS_WIDTH-1:0] RESET_PC      = '0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    output logic [ADDRESS_WIDTH-1:0] rom_addr,
    input  logic [DATA_WIDTH-1:0]    rom_data,
    input  logic                     redirect_valid,
    input  logic [ADDRESS_WIDTH-1:0] redirect_pc,
    output logic                     instr_valid,
    input  logic                     instr_ready,
    output logic [DATA_WIDTH-1:0]    instr,
    output logic [ADDRESS_WIDTH-1:0] instr_pc,
    output logic                     misalign_err
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    typedef struct packed {
        logic [ADDRESS_WIDTH-1:0] pc;
        logic [DATA_WIDTH-1:0]    instr;
    } entry_t;

    entry_t                   r_mem [DEPTH];
    logic [ADDRESS_WIDTH-1:0] r_fpc;
    logic [PTR_W-1:0]         r_rptr;
    logic [PTR_W-1:0]         r_wptr;
    logic [CNT_W-1:0]         r_count;
    logic                     r_halted;
    logic                     r_misalign_err;

    logic w_push;
    logic w_pop;
    logic w_misalign;

    // Push only when not full at the start of the cycle; pop cannot free a slot combinationally.
    assign w_push      = !redirect_valid && !r_halted && (r_count != FULL_CNT);
    assign w_pop       = instr_valid && instr_ready && !redirect_valid;
    assign instr_valid = (r_count != '0);

`ifdef FETCH_MISALIGN_CHK_EN
    assign w_misalign = redirect_valid && (redirect_pc[1:0] != 2'b00);
`else
    logic w_unused_lsb;
    assign w_unused_lsb = ^redirect_pc[1:0];
    assign w_misalign   = 1'b0;
`endif

    assign rom_addr     = r_fpc;
    assign instr        = r_mem[r_rptr].instr;
    assign instr_pc     = r_mem[r_rptr].pc;
    assign misalign_err = r_misalign_err;

    // Queue storage: capture {fetch PC, ROM word} at the write pointer on push.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_push) begin
            r_mem[r_wptr] <= '{pc: r_fpc, instr: rom_data};
        end
    end

    // Fetch PC, pointers, occupancy and sticky error; redirect overrides push and pop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fpc          <= RESET_PC;
            r_rptr         <= '0;
            r_wptr         <= '0;
            r_count        <= '0;
            r_halted       <= 1'b0;
            r_misalign_err <= 1'b0;
        end else if (redirect_valid) begin
            r_rptr  <= '0;
            r_wptr  <= '0;
            r_count <= '0;
            r_fpc   <= {redirect_pc[ADDRESS_WIDTH-1:2], 2'b00};
            if (w_misalign) begin
                r_halted       <= 1'b1;
                r_misalign_err <= 1'b1;
            end
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + PTR_W'(1);
                r_fpc  <= r_fpc + ADDRESS_WIDTH'(4);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + PTR_W'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + CNT_W'(1);
            end else if (w_pop && !w_push) begin
                r_count <= r_count - CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: randomized and directed checks of fetch_unit against a queue-based model.
module tb_fetch_unit;

    localparam int unsigned DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] rom_addr;
    logic [31:0] rom_data;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        instr_valid;
    logic        instr_ready = 1'b1;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        misalign_err;
    logic [31:0] salt = '0;

    logic [31:0] w2_rom_addr;
    logic        w2_valid;
    logic [31:0] w2_instr;
    logic [31:0] w2_pc;
    logic        w2_err;

    int checks = 0;
    int failures = 0;

    assign rom_data = rom_addr ^ salt;

    fetch_unit #(.ADDRESS_WIDTH(32), .DATA_WIDTH(32), .DEPTH(DEPTH), .RESET_PC(32'h0)) u_dut (
        .clk(clk), .rst_n(rst_n), .rom_addr(rom_addr), .rom_data(rom_data),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr),
        .instr_pc(instr_pc), .misalign_err(misalign_err)
    );

    fetch_unit #(.ADDRESS_WIDTH(32), .DATA_WIDTH(32), .DEPTH(DEPTH), .RESET_PC(32'hFFFF_FFF8)) u_wrap (
        .clk(clk), .rst_n(rst_n), .rom_addr(w2_rom_addr), .rom_data(w2_rom_addr),
        .redirect_valid(1'b0), .redirect_pc(32'h0),
        .instr_valid(w2_valid), .instr_ready(1'b1), .instr(w2_instr),
        .instr_pc(w2_pc), .misalign_err(w2_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: a queue of {pc, word}, plus fetch PC and halt/error flags.
    typedef struct { logic [31:0] pc; logic [31:0] ins; } ent_t;
    ent_t        m_q[$];
    logic [31:0] m_fpc = 32'h0;
    bit          m_halt = 1'b0;
    bit          m_err = 1'b0;

    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            m_q.delete();
            m_fpc  = 32'h0;
            m_halt = 1'b0;
            m_err  = 1'b0;
        end else if (redirect_valid) begin
            m_q.delete();
            m_fpc = redirect_pc & 32'hFFFF_FFFC;
`ifdef FETCH_MISALIGN_CHK_EN
            if (redirect_pc[1:0] != 2'b00) begin
                m_halt = 1'b1;
                m_err  = 1'b1;
            end
`endif
        end else begin
            bit do_push;
            bit do_pop;
            do_push = !m_halt && (m_q.size() < DEPTH);
            do_pop  = (m_q.size() != 0) && instr_ready;
            if (do_pop) void'(m_q.pop_front());
            if (do_push) begin
                ent_t e;
                e.pc  = m_fpc;
                e.ins = m_fpc ^ salt;
                m_q.push_back(e);
                m_fpc = m_fpc + 32'd4;
            end
        end
    end

    // Per-cycle comparison of DUT outputs against the model, away from the active edge.
    initial forever begin
        @(negedge clk);
        chk("valid", {31'b0, instr_valid}, {31'b0, m_q.size() != 0});
        chk("rom_addr", rom_addr, m_fpc);
        chk("misalign_err", {31'b0, misalign_err}, {31'b0, m_err});
        if (m_q.size() != 0) begin
            chk("instr_pc", instr_pc, m_q[0].pc);
            chk("instr", instr, m_q[0].ins);
        end
    end

    task automatic reset_dut();
        @(negedge clk);
        #1 rst_n = 1'b0;
        @(negedge clk);
        #1 rst_n = 1'b1;
    endtask

    initial begin
        logic [31:0] r;
        // Reset values and in-order sustained fetch, plus PC wrap on the second instance.
        repeat (2) @(negedge clk);
        chk("rst_valid", {31'b0, instr_valid}, 32'h0);
        chk("rst_instr", instr, 32'h0);
        chk("rst_pc", instr_pc, 32'h0);
        chk("rst_rom_addr", rom_addr, 32'h0);
        chk("rst_err", {31'b0, misalign_err}, 32'h0);
        chk("rst_wrap_addr", w2_rom_addr, 32'hFFFF_FFF8);
        #1 rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("seq_valid", {31'b0, instr_valid}, 32'h1);
            chk("seq_pc", instr_pc, 32'(4 * i));
            if (i < 3) chk("wrap_pc", w2_pc, 32'hFFFF_FFF8 + 32'(4 * i));
        end

        // Backpressure: fill to DEPTH, hold, then drain.
        instr_ready = 1'b0;
        reset_dut();
        repeat (6) @(negedge clk);
        chk("bp_rom_addr", rom_addr, 32'h10);
        chk("bp_head_pc", instr_pc, 32'h0);
        chk("bp_valid", {31'b0, instr_valid}, 32'h1);
        #1 instr_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            chk("drain_pc", instr_pc, 32'(4 * i));
        end

        // Redirect with three entries queued and ready high.
        instr_ready = 1'b0;
        reset_dut();
        repeat (3) @(negedge clk);
        #1 begin instr_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h100; end
        @(negedge clk);
        chk("rd_valid", {31'b0, instr_valid}, 32'h0);
        chk("rd_rom_addr", rom_addr, 32'h100);
        #1 redirect_valid = 1'b0;
        @(negedge clk);
        chk("rd_pc0", instr_pc, 32'h100);
        @(negedge clk);
        chk("rd_pc1", instr_pc, 32'h104);

        // Misaligned redirect.
        reset_dut();
        repeat (2) @(negedge clk);
        #1 begin redirect_valid = 1'b1; redirect_pc = 32'h102; end
        @(negedge clk);
        chk("mis_rom_addr", rom_addr, 32'h100);
        #1 redirect_valid = 1'b0;
        @(negedge clk);
`ifdef FETCH_MISALIGN_CHK_EN
        chk("mis_err", {31'b0, misalign_err}, 32'h1);
        chk("mis_valid", {31'b0, instr_valid}, 32'h0);
        repeat (3) @(negedge clk);
        chk("mis_hold_addr", rom_addr, 32'h100);
        chk("mis_hold_valid", {31'b0, instr_valid}, 32'h0);
`else
        chk("mis_pc", instr_pc, 32'h100);
        chk("mis_err", {31'b0, misalign_err}, 32'h0);
`endif

        // Randomized traffic with aligned redirects, including near-wrap targets.
        reset_dut();
        salt = $urandom;
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            #1;
            instr_ready    = ((i % 64) < 12) ? 1'b0 : ($urandom_range(0, 3) != 0);
            redirect_valid = ($urandom_range(0, 19) == 0);
            r = $urandom;
            if ($urandom_range(0, 3) == 0) r = 32'hFFFF_FFF0;
            redirect_pc = r & 32'hFFFF_FFFC;
        end
        redirect_valid = 1'b0;

        // Asynchronous reset in the middle of a drain.
        instr_ready = 1'b0;
        reset_dut();
        repeat (4) @(negedge clk);
        #1 instr_ready = 1'b1;
        repeat (2) @(negedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_valid", {31'b0, instr_valid}, 32'h0);
        chk("arst_rom_addr", rom_addr, 32'h0);
        chk("arst_pc", instr_pc, 32'h0);
        chk("arst_instr", instr, 32'h0);
        @(negedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("arst_restart_pc", instr_pc, 32'h0);
        chk("arst_restart_valid", {31'b0, instr_valid}, 32'h1);
        @(negedge clk);
        chk("arst_restart_pc1", instr_pc, 32'h4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
